usb_cdc_chan_mux: RTL and testbench

Pin-side multiplexer between a single 8-bit external byte interface and a CHANNELS-wide usb_cdc application interface. Sits between the chip-level pin wrapper and usb_cdc, so every CDC channel is reachable through one set of pins.
- Pin→USB: per-channel FIFOs, with the target channel selected per byte.
- USB→pin: an arbiter merges all channels into one output register tagged with the channel ID.

---
 rtl/usb_cdc_mux_pkg.sv | 21 ++
 rtl/cdc_sync_fifo.sv | 59 +++++
 rtl/usb_cdc_chan_mux.sv | 151 +++++++++++++++
 tb/tb_usb_cdc_chan_mux.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cdc_mux_pkg.sv
// -----------------------------------------------------------------------------
// usb_cdc_mux_pkg
// Shared types and helpers for the usb_cdc pin-side channel multiplexer.
//   BYTE_W     : width of one data byte on every interface.
//   arb_mode_e : arbitration policy of the USB->pin merge.
//   ch_w(n)    : width of a channel-ID field for n channels (never below 1).
// -----------------------------------------------------------------------------
package usb_cdc_mux_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_sync_fifo.sv
// -----------------------------------------------------------------------------
// cdc_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always present
// on rd_data while empty is low; rd_en pops it.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO).
//   wr_en/wr_data: push request and data (ignored while full).
//   rd_en        : pop request (ignored while empty).
//   rd_data      : head entry.
//   full/empty   : occupancy flags.
// -----------------------------------------------------------------------------
module cdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is carried
  // entirely by the pointers, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/usb_cdc_chan_mux.sv
// -----------------------------------------------------------------------------
// usb_cdc_chan_mux
// Pin-side multiplexer between one 8-bit external byte interface and a
// CHANNELS-wide usb_cdc application interface.
//   Pin->USB : the byte on pin_in_* is steered by pin_in_ch_i into a per-channel
//              FWFT FIFO whose head drives cdc_in_*[c]. Bytes addressed to a
//              channel >= CHANNELS are swallowed and flagged on bad_ch_o.
//   USB->pin : an arbiter (round-robin or fixed priority) picks one valid
//              cdc_out channel into a one-entry output register pin_out_*,
//              tagged with the source channel.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset.
//   pin_in_data/ch/valid/ready   : byte stream from the pins.
//   pin_out_data/ch/valid/ready  : byte stream to the pins.
//   cdc_in_data/valid/ready      : per-channel streams into usb_cdc.
//   cdc_out_data/valid/ready     : per-channel streams out of usb_cdc.
//   bad_ch_o                     : sticky illegal-channel flag.
// -----------------------------------------------------------------------------
module usb_cdc_chan_mux
  import usb_cdc_mux_pkg::BYTE_W, usb_cdc_mux_pkg::ch_w, usb_cdc_mux_pkg::arb_mode_e;
#(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_RR     = 1,
  parameter int CH_W       = ch_w(CHANNELS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [BYTE_W-1:0]          pin_in_data_i,
  input  logic [CH_W-1:0]            pin_in_ch_i,
  input  logic                       pin_in_valid_i,
  output logic                       pin_in_ready_o,
  output logic [BYTE_W-1:0]          pin_out_data_o,
  output logic [CH_W-1:0]            pin_out_ch_o,
  output logic                       pin_out_valid_o,
  input  logic                       pin_out_ready_i,
  output logic [BYTE_W*CHANNELS-1:0] cdc_in_data_o,
  output logic [CHANNELS-1:0]        cdc_in_valid_o,
  input  logic [CHANNELS-1:0]        cdc_in_ready_i,
  input  logic [BYTE_W*CHANNELS-1:0] cdc_out_data_i,
  input  logic [CHANNELS-1:0]        cdc_out_valid_i,
  output logic [CHANNELS-1:0]        cdc_out_ready_o,
  output logic                       bad_ch_o
);

  localparam arb_mode_e ARB_MODE = (ARB_RR != 0) ? usb_cdc_mux_pkg::ARB_RR
                                                 : usb_cdc_mux_pkg::ARB_FIXED;

  // ---------------------------------------------------------------------------
  // Pin -> USB
  // ---------------------------------------------------------------------------
  logic                ch_legal;
  logic                sel_full;
  logic [CHANNELS-1:0] fifo_full;
  logic [CHANNELS-1:0] fifo_empty;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ch_legal = 1'b0;
    sel_full = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pin_in_ch_i == CH_W'(c)) begin
        ch_legal = 1'b1;
        sel_full = fifo_full[c];
      end
    end
  end

  // Illegal channels are always ready so a stray byte can never stall the pins.
  // A full FIFO stays not-ready even if it pops this cycle (no write bypass).
  assign pin_in_ready_o = !ch_legal || !sel_full;
  assign cdc_in_valid_o = ~fifo_empty;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic wr_en;
    assign wr_en = pin_in_valid_i && (pin_in_ch_i == CH_W'(c)) && !fifo_full[c];

    cdc_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en   (wr_en),
      .wr_data (pin_in_data_i),
      .rd_en   (cdc_in_ready_i[c]),
      .rd_data (cdc_in_data_o[c*BYTE_W +: BYTE_W]),
      .full    (fifo_full[c]),
      .empty   (fifo_empty[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                             bad_ch_o <= 1'b0;
    else if (pin_in_valid_i && !ch_legal)  bad_ch_o <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // USB -> pin arbiter and output register
  // ---------------------------------------------------------------------------
  logic                load_en;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_ch;
  logic [BYTE_W-1:0]   gnt_data;
  logic [CHANNELS-1:0] gnt_onehot;
  logic [CH_W-1:0]     rr_ptr;

  // The register can take a new byte when it is empty or being drained now.
  assign load_en = !pin_out_valid_o || pin_out_ready_i;

  // Scan CHANNELS candidates; round-robin starts one past the last grant.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_found  = 1'b0;
    gnt_ch     = '0;
    gnt_data   = '0;
    gnt_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (ARB_MODE == usb_cdc_mux_pkg::ARB_RR) ? (int'(rr_ptr) + 1 + i) % CHANNELS : i;
      if (!gnt_found && cdc_out_valid_i[idx]) begin
        gnt_found       = 1'b1;
        gnt_ch          = CH_W'(idx);
        gnt_data        = cdc_out_data_i[idx*BYTE_W +: BYTE_W];
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  assign cdc_out_ready_o = (load_en && gnt_found && !rst_i) ? gnt_onehot : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pin_out_valid_o <= 1'b0;
      pin_out_data_o  <= '0;
      pin_out_ch_o    <= '0;
      rr_ptr          <= CH_W'(CHANNELS - 1);
    end else if (load_en) begin
      if (gnt_found) begin
        pin_out_valid_o <= 1'b1;
        pin_out_data_o  <= gnt_data;
        pin_out_ch_o    <= gnt_ch;
        rr_ptr          <= gnt_ch;
      end else begin
        pin_out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_cdc_chan_mux.sv
// -----------------------------------------------------------------------------
// tb_usb_cdc_chan_mux
// Two instances share the pin->USB stimulus: dut_rr (round-robin) and dut_fp
// (fixed priority); each has its own USB->pin sources and pin consumer.
// CH_W is widened to 2 so channel IDs 2 and 3 (illegal) can be driven.
// A queue-based reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_usb_cdc_chan_mux;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pin_in_data;
  logic [1:0]  pin_in_ch;
  logic        pin_in_valid;
  logic [1:0]  cdc_in_ready;

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [15:0] out_data   [2];
  logic [1:0]  out_valid  [2];
  logic        pout_ready [2];

  logic        pin_in_ready  [2];
  logic [15:0] cdc_in_data   [2];
  logic [1:0]  cdc_in_valid  [2];
  logic [7:0]  pout_data     [2];
  logic [1:0]  pout_ch       [2];
  logic        pout_valid    [2];
  logic [1:0]  cdc_out_ready [2];
  logic        bad_ch        [2];

  always #5 clk = ~clk;

  usb_cdc_chan_mux #(.CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .ARB_RR(1), .CH_W(2)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .pin_in_data_i(pin_in_data), .pin_in_ch_i(pin_in_ch),
    .pin_in_valid_i(pin_in_valid), .pin_in_ready_o(pin_in_ready[0]),
    .pin_out_data_o(pout_data[0]), .pin_out_ch_o(pout_ch[0]),
    .pin_out_valid_o(pout_valid[0]), .pin_out_ready_i(pout_ready[0]),
    .cdc_in_data_o(cdc_in_data[0]), .cdc_in_valid_o(cdc_in_valid[0]),
    .cdc_in_ready_i(cdc_in_ready),
    .cdc_out_data_i(out_data[0]), .cdc_out_valid_i(out_valid[0]),
    .cdc_out_ready_o(cdc_out_ready[0]), .bad_ch_o(bad_ch[0])
  );

  usb_cdc_chan_mux #(.CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .ARB_RR(0), .CH_W(2)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .pin_in_data_i(pin_in_data), .pin_in_ch_i(pin_in_ch),
    .pin_in_valid_i(pin_in_valid), .pin_in_ready_o(pin_in_ready[1]),
    .pin_out_data_o(pout_data[1]), .pin_out_ch_o(pout_ch[1]),
    .pin_out_valid_o(pout_valid[1]), .pin_out_ready_i(pout_ready[1]),
    .cdc_in_data_o(cdc_in_data[1]), .cdc_in_valid_o(cdc_in_valid[1]),
    .cdc_in_ready_i(cdc_in_ready),
    .cdc_out_data_i(out_data[1]), .cdc_out_valid_i(out_valid[1]),
    .cdc_out_ready_o(cdc_out_ready[1]), .bad_ch_o(bad_ch[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] q [NCH][$];
  bit         m_bad;
  bit         m_ov  [2];
  logic [7:0] m_od  [2];
  int         m_och [2];
  int         m_rr  [2];
  bit         src_acc [2][NCH];
  int         src_cnt [2][NCH];
  bit         pin_acc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_bad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ov[k]  = 1'b0;
      m_od[k]  = 8'h00;
      m_och[k] = 0;
      m_rr[k]  = NCH - 1;
    end
  endtask

  // Round-robin searches from last grant + 1; fixed priority from channel 0.
  function automatic int grant(input int k);
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (k == 0) ? (m_rr[k] + 1 + i) % NCH : i;
      if (out_valid[k][c]) return c;
    end
    return -1;
  endfunction

  // Compare all outputs at the falling edge, advance the model, then move to
  // just after the next rising edge.
  task automatic step();
    bit exp_rdy;
    bit full_pre [NCH];
    @(negedge clk);
    exp_rdy = (pin_in_ch >= NCH) ? 1'b1 : (q[pin_in_ch].size() < DEPTH);
    for (int k = 0; k < 2; k++) begin
      logic [1:0] ev;
      logic [1:0] er;
      int g;
      bit load;
      ev = '0;
      for (int c = 0; c < NCH; c++) ev[c] = (q[c].size() != 0);
      check($sformatf("pin_in_ready[%0d]", k), 32'(pin_in_ready[k]), 32'(exp_rdy));
      check($sformatf("cdc_in_valid[%0d]", k), 32'(cdc_in_valid[k]), 32'(ev));
      for (int c = 0; c < NCH; c++)
        if (ev[c]) check($sformatf("cdc_in_data[%0d].ch%0d", k, c),
                         32'(cdc_in_data[k][c*8 +: 8]), 32'(q[c][0]));
      check($sformatf("bad_ch[%0d]", k), 32'(bad_ch[k]), 32'(m_bad));
      check($sformatf("pin_out_valid[%0d]", k), 32'(pout_valid[k]), 32'(m_ov[k]));
      if (m_ov[k]) begin
        check($sformatf("pin_out_data[%0d]", k), 32'(pout_data[k]), 32'(m_od[k]));
        check($sformatf("pin_out_ch[%0d]", k), 32'(pout_ch[k]), 32'(m_och[k]));
      end
      g    = grant(k);
      load = !m_ov[k] || pout_ready[k];
      er   = (!rst && load && g >= 0) ? 2'(1 << g) : 2'b00;
      check($sformatf("cdc_out_ready[%0d]", k), 32'(cdc_out_ready[k]), 32'(er));
    end

    // Advance model with the inputs held across this edge.
    pin_acc = pin_in_valid && exp_rdy;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) src_acc[k][c] = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) full_pre[c] = (q[c].size() >= DEPTH);
      for (int c = 0; c < NCH; c++)
        if (cdc_in_ready[c] && q[c].size() != 0) void'(q[c].pop_front());
      if (pin_in_valid && pin_in_ch < NCH && !full_pre[pin_in_ch])
        q[pin_in_ch].push_back(pin_in_data);
      if (pin_in_valid && pin_in_ch >= NCH) m_bad = 1'b1;
      for (int k = 0; k < 2; k++) begin
        int g;
        g = grant(k);
        if (!m_ov[k] || pout_ready[k]) begin
          if (g >= 0) begin
            m_ov[k]  = 1'b1;
            m_od[k]  = out_data[k][g*8 +: 8];
            m_och[k] = g;
            m_rr[k]  = g;
            src_acc[k][g] = 1'b1;
          end else begin
            m_ov[k] = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Sources keep valid/data stable until accepted, then present the next byte.
  task automatic drive_src(input int k, input bit all_valid);
    for (int c = 0; c < NCH; c++) begin
      if (src_acc[k][c]) src_cnt[k][c]++;
      if (!out_valid[k][c] || src_acc[k][c]) begin
        out_valid[k][c]        = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
        out_data[k][c*8 +: 8]  = ((c == 0) ? 8'hA0 : 8'hB0) + 8'(src_cnt[k][c]);
      end
      src_acc[k][c] = 1'b0;
    end
  endtask

  task automatic drive_pin_random();
    if (!pin_in_valid || pin_acc) begin
      pin_in_valid = ($urandom_range(0, 2) != 0);
      pin_in_ch    = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(2, 3))
                                                  : 2'($urandom_range(0, 1));
      pin_in_data  = 8'($urandom);
    end
    pin_acc = 1'b0;
  endtask

  task automatic idle_inputs();
    pin_in_valid = 1'b0;
    pin_in_ch    = 2'd0;
    pin_in_data  = 8'h00;
    cdc_in_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      out_valid[k]  = 2'b00;
      out_data[k]   = 16'h0000;
      pout_ready[k] = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        src_cnt[k][c] = 0;
        src_acc[k][c] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    pin_acc = 1'b0;
    // Reset with random inputs on every port.
    rst          = 1'b1;
    pin_in_valid = 1'b1;
    pin_in_ch    = 2'($urandom_range(0, 1));
    pin_in_data  = 8'($urandom);
    cdc_in_ready = 2'($urandom);
    for (int k = 0; k < 2; k++) begin
      out_valid[k]  = 2'b11;
      out_data[k]   = 16'($urandom);
      pout_ready[k] = 1'($urandom);
      for (int c = 0; c < NCH; c++) begin
        src_cnt[k][c] = 0;
        src_acc[k][c] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check("reset.pin_out_data", 32'(pout_data[k]), 32'h0);
      check("reset.pin_out_ch", 32'(pout_ch[k]), 32'h0);
      check("reset.cdc_out_ready", 32'(cdc_out_ready[k]), 32'h0);
    end
    idle_inputs();
    rst = 1'b0;
    step();

    // Latency and order on channel 1.
    pin_in_ch = 2'd1; pin_in_data = 8'h41; pin_in_valid = 1'b1;
    step();
    check("lat.valid", 32'(cdc_in_valid[0]), 32'b10);
    check("lat.data0", 32'(cdc_in_data[0][15:8]), 32'h41);
    pin_in_data = 8'h42;
    step();
    pin_in_valid = 1'b0;
    cdc_in_ready = 2'b10;
    step();
    check("lat.data1", 32'(cdc_in_data[0][15:8]), 32'h42);
    step();
    check("lat.drained", 32'(cdc_in_valid[0][1]), 32'h0);
    cdc_in_ready = 2'b00;

    // Fill channel 0, verify per-channel ready and no bypass when full.
    pin_in_ch = 2'd0; pin_in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pin_in_data = 8'h10 + 8'(i);
      step();
    end
    pin_in_data = 8'h14;
    #1 check("full.ready_ch0", 32'(pin_in_ready[0]), 32'h0);
    pin_in_ch = 2'd1;
    #1 check("full.ready_ch1", 32'(pin_in_ready[0]), 32'h1);
    pin_in_ch = 2'd0;
    step();
    cdc_in_ready = 2'b01;
    step();
    cdc_in_ready = 2'b00;
    #1 check("full.ready_back", 32'(pin_in_ready[0]), 32'h1);
    step();
    pin_in_valid = 1'b0;
    cdc_in_ready = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      check("full.order", 32'(cdc_in_data[0][7:0]), 32'(8'h11 + 8'(i)));
      step();
    end
    check("full.empty", 32'(cdc_in_valid[0][0]), 32'h0);
    cdc_in_ready = 2'b00;

    // Bad channel: swallowed, sticky flag until reset.
    pin_in_ch = 2'd3; pin_in_data = 8'h99; pin_in_valid = 1'b1;
    #1 check("bad.ready", 32'(pin_in_ready[0]), 32'h1);
    step();
    pin_in_valid = 1'b0;
    check("bad.flag", 32'(bad_ch[0]), 32'h1);
    check("bad.no_fifo", 32'(cdc_in_valid[0]), 32'h0);
    repeat (3) step();
    check("bad.sticky", 32'(bad_ch[0]), 32'h1);
    do_reset();
    check("bad.cleared", 32'(bad_ch[0]), 32'h0);

    // Round-robin vs fixed priority with both channels streaming.
    idle_inputs();
    drive_src(0, 1'b1);
    drive_src(1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      step();
      check("rr.ch", 32'(pout_ch[0]), 32'(n % 2));
      check("rr.data", 32'(pout_data[0]), 32'(((n % 2) ? 8'hB0 : 8'hA0) + 8'(n / 2)));
      check("fp.ch", 32'(pout_ch[1]), 32'h0);
      check("fp.data", 32'(pout_data[1]), 32'(8'hA0 + 8'(n)));
      drive_src(0, 1'b1);
      drive_src(1, 1'b1);
    end

    // Backpressure on a held (ch1, 0x55) byte.
    idle_inputs();
    do_reset();
    out_valid[0] = 2'b10; out_data[0] = 16'h5500;
    step();
    out_valid[0] = 2'b01; out_data[0] = 16'h0066;
    pout_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp.data", 32'(pout_data[0]), 32'h55);
      check("bp.ch", 32'(pout_ch[0]), 32'h1);
      check("bp.no_grant", 32'(cdc_out_ready[0]), 32'h0);
    end
    pout_ready[0] = 1'b1;
    #1 check("bp.release_grant", 32'(cdc_out_ready[0]), 32'b01);
    step();
    check("bp.next", 32'({pout_ch[0], pout_data[0]}), 32'h066);
    out_valid[0] = 2'b00;
    step();

    // Randomized traffic with occasional reset.
    idle_inputs();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive_pin_random();
      cdc_in_ready = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        drive_src(k, 1'b0);
        pout_ready[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
